// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the 3x3 conv + ReLU + 2x2 max-pool front end.
package conv_pkg;

  localparam int DATA_W = 16;
  localparam int KERNEL = 3;
  localparam int NTAP   = KERNEL * KERNEL;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 36;

  typedef enum logic [2:0] {IDLE, LOAD, CONV, POOL, DONE} state_t;

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
    return x[ACC_W-1] ? '0 : x;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (x > hi)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x < lo)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mac3x3.sv
// Combinational 9-tap signed multiply-accumulate; result is ReLU'd then saturated to DATA_W.
module mac3x3
  import conv_pkg::*;
(
  input  logic signed [DATA_W-1:0] pix  [NTAP],
  input  logic signed [DATA_W-1:0] coef [NTAP],
  output logic signed [DATA_W-1:0] res
);

  logic signed [PROD_W-1:0] prod [NTAP];
  logic signed [ACC_W-1:0]  acc;

  always_comb begin
    acc = '0;
    for (int t = 0; t < NTAP; t++) begin
      prod[t] = pix[t] * coef[t];
      acc     = acc + ACC_W'(prod[t]);
    end
    res = sat(relu(acc));
  end

endmodule

// File: rtl/conv_pool_top.sv
// Captures a padded square image, runs a 3x3 valid convolution with an internal kernel,
// applies ReLU and emits 2x2/stride-2 max-pooled results one per cycle with their index.
module conv_pool_top
  import conv_pkg::*;
#(
  parameter int IMG = 14,
  parameter int PAD = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic                     w_load,
  input  logic signed [DATA_W-1:0] img_in,
  output logic signed [DATA_W-1:0] pooling_out,
  output logic                     done_pooling,
  output logic [15:0]              addr
);

  localparam int SIZE      = IMG + 2 * PAD;
  localparam int NPIX      = SIZE * SIZE;
  localparam int NCONV     = IMG * IMG;
  localparam int POOL_SIDE = IMG / 2;
  localparam int NPOOL     = POOL_SIDE * POOL_SIDE;
  localparam int PIX_AW    = $clog2(NPIX);
  localparam int CONV_AW   = $clog2(NCONV);
  localparam int RC_W      = $clog2(SIZE);

  state_t state, state_nxt;

  logic [PIX_AW-1:0]  pix_cnt;
  logic [RC_W-1:0]    cr, cc, pr, pc;
  logic [15:0]        pn;
  logic               last_pix, last_conv, last_pool;

  logic signed [DATA_W-1:0] kern    [NTAP];
  logic signed [DATA_W-1:0] img_buf [NPIX];
  logic signed [DATA_W-1:0] conv_buf[NCONV];
  logic signed [DATA_W-1:0] win     [NTAP];
  logic signed [DATA_W-1:0] quad    [4];
  logic signed [DATA_W-1:0] conv_res;
  logic signed [DATA_W-1:0] pool_max;
  logic [CONV_AW-1:0]       conv_widx;

  assign last_pix  = (pix_cnt == PIX_AW'(NPIX - 1));
  assign last_conv = (cr == RC_W'(IMG - 1)) && (cc == RC_W'(IMG - 1));
  assign last_pool = (pn == 16'(NPOOL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A new i_load restarts capture from any state.
  always_comb begin
    state_nxt = state;
    if (i_load)
      state_nxt = LOAD;
    else begin
      case (state)
        LOAD:    if (last_pix)  state_nxt = CONV;
        CONV:    if (last_conv) state_nxt = POOL;
        POOL:    if (last_pool) state_nxt = DONE;
        IDLE:    state_nxt = IDLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_load) begin
      pix_cnt <= '0;
      cr      <= '0;
      cc      <= '0;
      pr      <= '0;
      pc      <= '0;
      pn      <= '0;
    end else begin
      case (state)
        LOAD: pix_cnt <= pix_cnt + 1'b1;
        CONV: begin
          if (cc == RC_W'(IMG - 1)) begin
            cc <= '0;
            cr <= cr + 1'b1;
          end else begin
            cc <= cc + 1'b1;
          end
        end
        POOL: begin
          pn <= pn + 1'b1;
          if (pc == RC_W'(POOL_SIDE - 1)) begin
            pc <= '0;
            pr <= pr + 1'b1;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Kernel is loaded independently of the capture state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < NTAP; t++) kern[t] <= '0;
    end else if (w_load) begin
      for (int t = 0; t < NTAP; t++) kern[t] <= DATA_W'(t);
    end
  end

  always_comb begin
    for (int i = 0; i < KERNEL; i++)
      for (int j = 0; j < KERNEL; j++)
        win[i*KERNEL+j] = img_buf[PIX_AW'((int'(cr) + i) * SIZE + int'(cc) + j)];
  end

  mac3x3 u_mac (
    .pix  (win),
    .coef (kern),
    .res  (conv_res)
  );

  assign conv_widx = CONV_AW'(int'(cr) * IMG + int'(cc));

  always_ff @(posedge clk) begin
    if (state == LOAD) img_buf[pix_cnt]    <= img_in;
    if (state == CONV) conv_buf[conv_widx] <= conv_res;
  end

  always_comb begin
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        quad[a*2+b] = conv_buf[CONV_AW'((2 * int'(pr) + a) * IMG + 2 * int'(pc) + b)];
    pool_max = quad[0];
    for (int t = 1; t < 4; t++)
      if (quad[t] > pool_max) pool_max = quad[t];
  end

  // Outputs only move during POOL; done rises one cycle after the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pooling_out  <= '0;
      addr         <= '0;
      done_pooling <= 1'b0;
    end else begin
      if (i_load)
        done_pooling <= 1'b0;
      else if (state == DONE)
        done_pooling <= 1'b1;
      if (state == POOL && !i_load) begin
        pooling_out <= pool_max;
        addr        <= pn;
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_top.sv
// Randomized self-checking bench for conv_pool_top against a plain-arithmetic reference model.
module tb_conv_pool_top;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_load = 1'b0;
  logic               w_load = 1'b0;
  logic signed [15:0] img_in = '0;
  logic signed [15:0] pooling_out;
  logic               done_pooling;
  logic [15:0]        addr;

  int n_checks = 0;
  int n_errors = 0;
  int img [256];
  bit kern_on = 1'b0;
  int last_out = 0;
  int last_addr = 0;

  conv_pool_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (i_load),
    .w_load       (w_load),
    .img_in       (img_in),
    .pooling_out  (pooling_out),
    .done_pooling (done_pooling),
    .addr         (addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int conv_ref(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += longint'(kern_on ? 3 * i + j : 0) * longint'(img[(r + i) * 16 + c + j]);
    if (s < 0) s = 0;
    if (s > 32767) s = 32767;
    return int'(s);
  endfunction

  function automatic int pool_ref(input int n);
    int rr = n / 7;
    int cc = n % 7;
    int m = conv_ref(2 * rr, 2 * cc);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        if (conv_ref(2 * rr + a, 2 * cc + b) > m) m = conv_ref(2 * rr + a, 2 * cc + b);
    return m;
  endfunction

  // mode 0: ramp 16r+c, 1: constant v, 2: random in [-v, v]
  task automatic fill(input int mode, input int v);
    for (int k = 0; k < 256; k++) begin
      case (mode)
        0:       img[k] = k;
        1:       img[k] = v;
        default: img[k] = int'($urandom_range(2 * v, 0)) - v;
      endcase
    end
  endtask

  task automatic load_pixels(input bit wl);
    i_load = 1'b1;
    w_load = wl;
    step(1);
    i_load = 1'b0;
    w_load = 1'b0;
    if (wl) kern_on = 1'b1;
    for (int k = 0; k < 256; k++) begin
      img_in = 16'(img[k]);
      step(1);
    end
  endtask

  task automatic check_pool(input string tag);
    step(196);
    check_val({tag, "_hold_addr"}, int'(addr), last_addr);
    check_val({tag, "_hold_out"}, int'(pooling_out), last_out);
    check_val({tag, "_done_early"}, int'(done_pooling), 0);
    for (int n = 0; n < 49; n++) begin
      step(1);
      check_val($sformatf("%s_out%0d", tag, n), int'(pooling_out), pool_ref(n));
      check_val($sformatf("%s_addr%0d", tag, n), int'(addr), n);
      check_val($sformatf("%s_done%0d", tag, n), int'(done_pooling), 0);
    end
    last_out  = pool_ref(48);
    last_addr = 48;
    step(1);
    check_val({tag, "_done"}, int'(done_pooling), 1);
    check_val({tag, "_done_addr"}, int'(addr), 48);
    check_val({tag, "_done_out"}, int'(pooling_out), last_out);
  endtask

  initial begin
    step(2);
    check_val("rst_out", int'(pooling_out), 0);
    check_val("rst_addr", int'(addr), 0);
    check_val("rst_done", int'(done_pooling), 0);
    rst_n = 1'b1;
    step(1);

    fill(2, 500);
    load_pixels(1'b0);
    check_pool("nokern");

    fill(0, 0);
    load_pixels(1'b1);
    check_pool("ramp");

    fill(1, -100);
    load_pixels(1'b0);
    check_pool("neg");

    fill(1, 1000);
    load_pixels(1'b1);
    check_pool("sat");

    for (int r = 0; r < 2; r++) begin
      fill(2, 300);
      load_pixels(1'b0);
      check_pool($sformatf("rand%0d", r));
    end

    fill(2, 300);
    load_pixels(1'b0);
    step(50);
    check_val("restart_done_mid", int'(done_pooling), 0);
    fill(2, 300);
    load_pixels(1'b0);
    check_pool("restart");

    fill(2, 300);
    load_pixels(1'b0);
    step(196 + 21);
    check_val("midpool_addr", int'(addr), 20);
    check_val("midpool_out", int'(pooling_out), pool_ref(20));
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    kern_on   = 1'b0;
    last_out  = 0;
    last_addr = 0;
    check_val("midrst_out", int'(pooling_out), 0);
    check_val("midrst_addr", int'(addr), 0);
    check_val("midrst_done", int'(done_pooling), 0);
    step(600);
    check_val("idle_done", int'(done_pooling), 0);
    check_val("idle_addr", int'(addr), 0);
    check_val("idle_out", int'(pooling_out), 0);

    fill(2, 300);
    load_pixels(1'b1);
    check_pool("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_pool_top.md
Name: conv_pool_top

Overview:
- Single-channel CNN front end. Captures a zero-padded square image streamed one pixel per clock and applies a 3x3 convolution (stride 1, valid) with an internal kernel.
- The convolution result passes through ReLU, then 2x2 max pooling (stride 2).
- Pooled results are emitted one per cycle with an index address.
- Sits between the image/weight loader and the downstream classifier layer.

Parameters:
- IMG, 14, unpadded image side length (convolution output side = IMG).
- PAD, 1, zero-pad width per side; stored image side SIZE = IMG+2*PAD (default 16).
- Derived (localparam): POOL_SIDE = IMG/2 (7); NPOOL = POOL_SIDE*POOL_SIDE (49). IMG must be even.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_load  in  1  one-cycle start pulse for image capture.
- w_load  in  1  one-cycle pulse to (re)load the internal kernel.
- img_in  in  16 signed  pixel stream, row-major, padded image.
- pooling_out  out  16 signed  current pooled result.
- done_pooling  out  1  high once all NPOOL results are produced.
- addr  out  16  index (0..NPOOL-1, row-major) of the value on pooling_out.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset: state IDLE; pooling_out=0, addr=0, done_pooling=0; kernel registers cleared to 0.
- Reset asserted at any time aborts the operation and returns to IDLE.
- Kernel load: w_load sampled high sets kernel k[3i+j] = 3i+j (values 0..8, row-major, signed 16-bit).
- The kernel is independent of state and may coincide with i_load.
- States: IDLE -> LOAD -> CONV -> POOL -> DONE.
- IDLE/DONE -> LOAD: when i_load is sampled high.
- i_load during LOAD/CONV/POOL restarts LOAD and clears done_pooling.
- LOAD:
  - First pixel is sampled on the edge after the i_load edge.
  - One pixel is stored per cycle into buffer[row][col] for SIZE*SIZE cycles (256).
  - No valid strobe; img_in is assumed valid every LOAD cycle.
- CONV: for each output (r,c), r,c in 0..IMG-1, one output per cycle (IMG*IMG = 196 cycles).
  - conv = sum over i,j of k[3i+j]*buffer[r+i][c+j].
  - Products are 32-bit signed and accumulate at 36-bit.
  - Result is ReLU'd (negative -> 0), then saturated to 16-bit signed max 32767.
  - Stored in a conv buffer.
- POOL: NPOOL cycles.
  - Cycle n registers pooling_out = max of conv[2R..2R+1][2C..2C+1] and addr = n, where R = n/POOL_SIDE and C = n%POOL_SIDE.
  - Values are visible from the following cycle.
- DONE:
  - done_pooling=1, held until reset or next i_load.
  - pooling_out and addr hold the last result (addr = NPOOL-1).
- Outputs are constant outside POOL/DONE (hold previous values).
- Total latency from i_load edge to done_pooling high: 256+196+49+1 cycles.

Decomposition:
- Shared package conv_pkg:
  - DATA_W=16, KERNEL=3, state enum.
  - Saturate function and ReLU function.
- One natural sub-module: mac3x3 (combinational 9-tap signed multiply-accumulate with ReLU/saturation).
- FSM, buffers and pooling stay in the top.

Test Plan:
- Reset check: rst_n=0 for 2 cycles -> pooling_out=0, addr=0, done_pooling=0.
- Ramp image:
  - Stimulus: w_load and i_load pulsed together, then img_in = 16r+c for 256 cycles.
  - Expected conv(r,c) = 36*(16r+c)+906.
  - Expected pooled n = 1152R+72C+1518: addr0=1518, addr1=1590, addr7=2670, addr48=8862.
  - done_pooling rises after addr 48.
- ReLU/saturation:
  - All pixels -100 -> every pooling_out = 0.
  - All pixels 1000 -> conv = 36000 saturates, every pooling_out = 32767.
- No weight load: i_load only, after reset -> kernel 0, all 49 outputs = 0, done_pooling still asserted.
- Restart: i_load re-pulsed mid-CONV -> done_pooling stays 0, new 256-pixel capture used, results match the second image.
- Reset mid-POOL: rst_n=0 at addr=20 -> outputs cleared, IDLE, no done_pooling until a new i_load completes.
